// File: rtl/vga_fb_arbiter.sv
// Framebuffer port arbiter: display prefetch FIFO has priority, writer fills idle slots.
// Optional VGA_FB_UNDERRUN_CNT_EN adds a saturating underrun counter port.
module vga_fb_arbiter #(
    parameter int HRES       = 640,
    parameter int VRES       = 480,
    parameter int AW         = 19,
    parameter int DW         = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_start,
    input  logic          pix_req,
    output logic [DW-1:0] pix_data,
    output logic          pix_valid,
    output logic          underrun,
`ifdef VGA_FB_UNDERRUN_CNT_EN
    output logic [15:0]   underrun_cnt,
`endif
    input  logic          wr_valid,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ready,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int NPIX = HRES * VRES;
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = PW + 1;
    localparam logic [AW-1:0] LAST   = AW'(NPIX - 1);
    localparam logic [AW:0]   NPIX_W = (AW+1)'(NPIX);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          inflight;
    logic [DW-1:0] fifo [FIFO_DEPTH];
    logic [PW-1:0] rptr, wptr;
    logic [CW-1:0] count;
    logic          fetch_grant;
    logic          wr_go;
    logic          wr_in_range;
    logic          push;
    logic          pop;

    assign fetch_grant = (state == RUN) && !frame_start &&
                         ((count + CW'(inflight)) < CW'(FIFO_DEPTH));
    // rst gating keeps the write path quiet while reset is held
    assign wr_go       = wr_valid && !fetch_grant && !rst;
    assign wr_in_range = {1'b0, wr_addr} < NPIX_W;
    assign push        = inflight && !frame_start;
    assign pop         = pix_req && pix_valid && !frame_start;
    assign pix_valid   = (count != '0);
    assign pix_data    = pix_valid ? fifo[rptr] : '0;

    always_comb begin
        state_nxt = state;
        wr_ready  = wr_go;
        mem_addr  = addr_q;
        mem_we    = 1'b0;
        mem_wdata = wdata_q;
        if (fetch_grant) begin
            mem_addr = rd_addr;
        end else if (wr_go) begin
            mem_addr  = wr_addr;
            mem_wdata = wr_data;
            mem_we    = wr_in_range;
        end
        if (frame_start)
            state_nxt = RUN;
        else if (fetch_grant && rd_addr == LAST)
            state_nxt = DONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rd_addr  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            inflight <= 1'b0;
            rptr     <= '0;
            wptr     <= '0;
            count    <= '0;
            underrun <= 1'b0;
        end else begin
            state    <= state_nxt;
            addr_q   <= mem_addr;
            wdata_q  <= mem_wdata;
            inflight <= fetch_grant;
            if (frame_start)
                rd_addr <= '0;
            else if (fetch_grant)
                rd_addr <= rd_addr + AW'(1);
            if (frame_start) begin
                rptr  <= '0;
                wptr  <= '0;
                count <= '0;
            end else begin
                if (push)
                    wptr <= wptr + PW'(1);
                if (pop)
                    rptr <= rptr + PW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
            if (frame_start)
                underrun <= 1'b0;
            else if (pix_req && !pix_valid)
                underrun <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo[wptr] <= mem_rdata;
    end

`ifdef VGA_FB_UNDERRUN_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            underrun_cnt <= '0;
        else if (pix_req && !pix_valid && underrun_cnt != 16'hFFFF)
            underrun_cnt <= underrun_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: small frame, RAM model, shadow image as reference.
// Build with VGA_FB_UNDERRUN_CNT_EN to also exercise the underrun counter.
module tb_vga_fb_arbiter;

    localparam int HRES = 16;
    localparam int VRES = 8;
    localparam int AW   = 8;
    localparam int DW   = 8;
    localparam int FD   = 4;
    localparam int N    = HRES * VRES;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          frame_start = 1'b0;
    logic          pix_req = 1'b0;
    logic          wr_valid = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [DW-1:0] pix_data, mem_wdata, mem_rdata;
    logic          pix_valid, underrun, wr_ready, mem_we;
    logic [AW-1:0] mem_addr;
`ifdef VGA_FB_UNDERRUN_CNT_EN
    logic [15:0]   underrun_cnt;
`endif

    logic [DW-1:0] ram    [2**AW];
    logic [DW-1:0] shadow [2**AW];

    int n_tests = 0;
    int n_fail  = 0;
    int pop_idx = 0;
    int pops    = 0;
    int grants  = 0;
    bit wr_auto = 0;
    bit wr_keep = 0;
    logic [AW-1:0] last_addr;

    always #5 clk = ~clk;

    vga_fb_arbiter #(
        .HRES(HRES), .VRES(VRES), .AW(AW), .DW(DW), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .frame_start(frame_start),
        .pix_req(pix_req),
        .pix_data(pix_data),
        .pix_valid(pix_valid),
        .underrun(underrun),
`ifdef VGA_FB_UNDERRUN_CNT_EN
        .underrun_cnt(underrun_cnt),
`endif
        .wr_valid(wr_valid),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wr_ready(wr_ready),
        .mem_addr(mem_addr),
        .mem_we(mem_we),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_we)
            ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] init_pix(input int i);
        return DW'(i * 7 + 3);
    endfunction

    task automatic new_write();
        wr_addr  = AW'($urandom_range(0, 2**AW - 1));
        if (wr_keep && int'(wr_addr) < N)
            wr_data = shadow[wr_addr];
        else
            wr_data = DW'($urandom);
        wr_valid = 1'b1;
    endtask

    // one clock: sample at negedge+1, apply model, advance to next negedge
    task automatic tick();
        bit acc;
        #1;
        last_addr = mem_addr;
        if (pix_req && pix_valid) begin
            check("pop", 32'(pix_data), 32'(shadow[pop_idx % (2**AW)]));
            pop_idx++;
            pops++;
        end
        acc = wr_valid && wr_ready;
        if (acc) begin
            grants++;
            check("wr_we", 32'(mem_we), 32'(int'(wr_addr) < N));
            check("wr_addr", 32'(mem_addr), 32'(wr_addr));
            if (int'(wr_addr) < N) begin
                check("wr_data", 32'(mem_wdata), 32'(wr_data));
                shadow[wr_addr] = wr_data;
            end
        end else begin
            check("no_we", 32'(mem_we), 32'd0);
        end
        if (frame_start)
            pop_idx = 0;
        @(negedge clk);
        if (wr_auto && acc)
            new_write();
    endtask

    task automatic run_frame(input int gmin, input int gmax, input bit wr_on);
        int cyc;
        int g0;
        int gap;
        pops = 0;
        frame_start = 1'b1;
        if (wr_on) begin
            wr_auto = 1;
            wr_keep = 1;
            new_write();
        end
        tick();
        frame_start = 1'b0;
        repeat (8) tick();
        g0  = grants;
        cyc = 0;
        while (pops < N && cyc < 4000) begin
            pix_req = 1'b1;
            tick();
            pix_req = 1'b0;
            gap = $urandom_range(gmin, gmax);
            repeat (gap - 1) tick();
            cyc += gap;
        end
        wr_auto  = 0;
        wr_keep  = 0;
        wr_valid = 1'b0;
        check("frame_pops", 32'(pops), 32'(N));
        check("frame_underrun", 32'(underrun), 32'd0);
        if (wr_on)
            check("wr_share", 32'((grants - g0) * 2 >= cyc), 32'd1);
        repeat (4) tick();
        check("done_empty", 32'(pix_valid), 32'd0);
    endtask

    initial begin
        int bad;
        int g0;
        for (int i = 0; i < 2**AW; i++) begin
            ram[i]    = init_pix(i);
            shadow[i] = init_pix(i);
        end
        wr_valid = 1'b1;
        wr_addr  = AW'(20);
        wr_data  = 8'h55;
        #2;
        check("rst_valid", 32'(pix_valid), 32'd0);
        check("rst_data", 32'(pix_data), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_ready", 32'(wr_ready), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", 32'(mem_wdata), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst      = 1'b0;
        wr_valid = 1'b0;
        @(negedge clk);

        // underrun while idle
        pix_req = 1'b1;
        tick();
        pix_req = 1'b0;
        check("ur_set", 32'(underrun), 32'd1);
        check("ur_data", 32'(pix_data), 32'd0);
`ifdef VGA_FB_UNDERRUN_CNT_EN
        check("ur_cnt", 32'(underrun_cnt), 32'd1);
`endif
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("ur_clear", 32'(underrun), 32'd0);
`ifdef VGA_FB_UNDERRUN_CNT_EN
        check("ur_cnt_keep", 32'(underrun_cnt), 32'd1);
`endif

        // prefetch fill with a writer waiting behind it
        wr_valid = 1'b1;
        wr_addr  = AW'(10);
        wr_data  = 8'hAA;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("fill_addr", 32'(mem_addr), (i < 4) ? 32'(i) : 32'd10);
            check("fill_rdy", 32'(wr_ready), (i < 4) ? 32'd0 : 32'd1);
            tick();
        end
        wr_addr = AW'(200);
        wr_data = 8'h33;
        #1;
        check("oor_rdy", 32'(wr_ready), 32'd1);
        check("oor_we", 32'(mem_we), 32'd0);
        tick();
        wr_valid = 1'b0;
        repeat (3) tick();
        check("fill_valid", 32'(pix_valid), 32'd1);
        check("fill_head", 32'(pix_data), 32'(init_pix(0)));
        check("idle_hold", 32'(mem_addr), 32'd200);
        check("ram10", 32'(ram[10]), 32'hAA);
        check("ram200", 32'(ram[200]), 32'(init_pix(200)));

        // full frame at display rate with a greedy writer
        run_frame(2, 2, 1);

        // random image update while the fetch path is done
        g0 = grants;
        wr_auto = 1;
        new_write();
        repeat (60) tick();
        wr_auto  = 0;
        wr_valid = 1'b0;
        tick();
        check("done_grants", 32'(grants - g0), 32'd60);
        bad = 0;
        for (int i = 0; i < 2**AW; i++)
            if (ram[i] !== shadow[i])
                bad++;
        check("ram_image", 32'(bad), 32'd0);

        // stream the updated image with irregular request spacing
        run_frame(2, 4, 0);

        // restart while the read of address 100 is in flight
        pops = 0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (8) tick();
        for (int k = 0; k < 400; k++) begin
            pix_req = (k % 2 == 0);
            tick();
            pix_req = 1'b0;
            if (last_addr == AW'(100))
                break;
        end
        check("saw_100", 32'(last_addr), 32'd100);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        #1;
        check("restart_addr", 32'(mem_addr), 32'd0);
        repeat (6) tick();
        pops = 0;
        for (int k = 0; k < 10; k++) begin
            pix_req = 1'b1;
            tick();
            pix_req = 1'b0;
            tick();
        end
        check("restart_pops", 32'(pops), 32'd10);
        check("restart_underrun", 32'(underrun), 32'd0);

        // asynchronous reset mid-frame with writer active
        wr_valid = 1'b1;
        wr_addr  = AW'(5);
        wr_data  = 8'h77;
        tick();
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(pix_valid), 32'd0);
        check("arst_data", 32'(pix_data), 32'd0);
        check("arst_ready", 32'(wr_ready), 32'd0);
        check("arst_we", 32'(mem_we), 32'd0);
        check("arst_addr", 32'(mem_addr), 32'd0);
        check("arst_wdata", 32'(mem_wdata), 32'd0);
`ifdef VGA_FB_UNDERRUN_CNT_EN
        check("arst_cnt", 32'(underrun_cnt), 32'd0);
`endif
        repeat (3) begin
            @(posedge clk);
            #1;
            check("arst_hold_we", 32'(mem_we), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(wr_ready), 32'd1);
        wr_valid = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
